// File: rtl/mac_layer_sequencer.sv
// Initiator-side sequencer for one dense layer of the neuron MAC. For each neuron it clears
// the accumulator, streams input/weight pairs, presents the bias and returns the result.
// Optional stall counter enabled by defining PERF_CNT_EN.
module mac_layer_sequencer #(
    parameter int N_INPUTS  = 8,
    parameter int N_NEURONS = 4,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] in_addr,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] b_addr,
    input  logic [7:0]    in_data,
    input  logic [7:0]    w_data,
    input  logic [7:0]    b_data,
    output logic          mac_rst_acc,
    output logic          mac_ld_acc,
    output logic [7:0]    cur_input,
    output logic [7:0]    cur_weight,
    output logic [7:0]    cur_bias,
    input  logic [7:0]    mac_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [AW-1:0] out_idx
`ifdef PERF_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_ACC, S_BIAS, S_OUT, S_DONE} state_t;

    localparam logic [AW-1:0] K_LAST = AW'(N_INPUTS - 1);
    localparam logic [AW-1:0] N_LAST = AW'(N_NEURONS - 1);
    localparam logic [AW-1:0] N_STEP = AW'(N_INPUTS);
    localparam logic [AW-1:0] ONE    = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] n_q, n_d, k_q, k_d, base_q, base_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          rst_acc_q, rst_acc_d, ld_acc_q, ld_acc_d, out_valid_q, out_valid_d;
    logic [AW-1:0] in_addr_q, in_addr_d, w_addr_q, w_addr_d, b_addr_q, b_addr_d;
    logic [7:0]    out_data_q, out_data_d;
    logic [AW-1:0] out_idx_q, out_idx_d;
`ifdef PERF_CNT_EN
    logic [15:0]   stall_q, stall_d;
`endif

    assign cur_input  = in_data;
    assign cur_weight = w_data;
    assign cur_bias   = b_data;

    always_comb begin
        // NOTE: every _d starts from a default so no path through this block infers a latch.
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        base_d      = base_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rst_acc_d   = 1'b0;
        ld_acc_d    = 1'b0;
        out_valid_d = out_valid_q;
        in_addr_d   = in_addr_q;
        w_addr_d    = w_addr_q;
        b_addr_d    = b_addr_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
`ifdef PERF_CNT_EN
        stall_d     = stall_q;
`endif
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d   = S_CLR;
                n_d       = '0;
                base_d    = '0;
                busy_d    = 1'b1;
                rst_acc_d = 1'b1;
                in_addr_d = '0;
                w_addr_d  = '0;
`ifdef PERF_CNT_EN
                stall_d   = '0;
`endif
            end
            S_CLR: begin
                state_d  = S_ACC;
                k_d      = '0;
                ld_acc_d = 1'b1;
                if (K_LAST == '0) begin
                    b_addr_d = n_q;
                end else begin
                    in_addr_d = in_addr_q + ONE;
                    w_addr_d  = w_addr_q + ONE;
                end
            end
            // Addresses run one pair ahead of the data; the final ACC cycle fetches the bias.
            S_ACC: begin
                if (k_q == K_LAST) begin
                    state_d = S_BIAS;
                end else begin
                    k_d      = k_q + ONE;
                    ld_acc_d = 1'b1;
                    if (k_q + ONE == K_LAST) begin
                        b_addr_d = n_q;
                    end else begin
                        in_addr_d = in_addr_q + ONE;
                        w_addr_d  = w_addr_q + ONE;
                    end
                end
            end
            S_BIAS: begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                out_data_d  = mac_result;
                out_idx_d   = n_q;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (n_q == N_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_CLR;
                        n_d       = n_q + ONE;
                        base_d    = base_q + N_STEP;
                        rst_acc_d = 1'b1;
                        in_addr_d = '0;
                        w_addr_d  = base_q + N_STEP;
                    end
                end
`ifdef PERF_CNT_EN
                else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            k_q         <= '0;
            base_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rst_acc_q   <= 1'b0;
            ld_acc_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            b_addr_q    <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
`ifdef PERF_CNT_EN
            stall_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            base_q      <= base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rst_acc_q   <= rst_acc_d;
            ld_acc_q    <= ld_acc_d;
            out_valid_q <= out_valid_d;
            in_addr_q   <= in_addr_d;
            w_addr_q    <= w_addr_d;
            b_addr_q    <= b_addr_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
`ifdef PERF_CNT_EN
            stall_q     <= stall_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mac_rst_acc = rst_acc_q;
    assign mac_ld_acc  = ld_acc_q;
    assign out_valid   = out_valid_q;
    assign in_addr     = in_addr_q;
    assign w_addr      = w_addr_q;
    assign b_addr      = b_addr_q;
    assign out_data    = out_data_q;
    assign out_idx     = out_idx_q;
`ifdef PERF_CNT_EN
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Self-checking bench for mac_layer_sequencer: random memories, a MAC stub (bias ^ 8'h5A)
// and a layer-level reference model of the expected pair stream and results.
module tb_mac_layer_sequencer;

    localparam int NI = 4;
    localparam int NN = 4;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start_b, out_ready;

    logic          busy, done, mac_rst_acc, mac_ld_acc, out_valid;
    logic [AW-1:0] in_addr, w_addr, b_addr, out_idx;
    logic [7:0]    in_data, w_data, b_data, cur_input, cur_weight, cur_bias, mac_result, out_data;

    logic          busy_b, done_b, mac_rst_acc_b, mac_ld_acc_b, out_valid_b;
    logic [AW-1:0] in_addr_b, w_addr_b, b_addr_b, out_idx_b;
    logic [7:0]    in_data_b, w_data_b, b_data_b, cur_input_b, cur_weight_b, cur_bias_b;
    logic [7:0]    mac_result_b, out_data_b;
`ifdef PERF_CNT_EN
    logic [15:0]   stall_cnt, stall_cnt_b;
`endif

    logic [7:0] in_mem [256];
    logic [7:0] w_mem  [256];
    logic [7:0] b_mem  [256];

    mac_layer_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_addr(in_addr), .w_addr(w_addr), .b_addr(b_addr),
        .in_data(in_data), .w_data(w_data), .b_data(b_data),
        .mac_rst_acc(mac_rst_acc), .mac_ld_acc(mac_ld_acc),
        .cur_input(cur_input), .cur_weight(cur_weight), .cur_bias(cur_bias),
        .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx)
`ifdef PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    mac_layer_sequencer #(.N_INPUTS(1), .N_NEURONS(2), .AW(AW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .in_addr(in_addr_b), .w_addr(w_addr_b), .b_addr(b_addr_b),
        .in_data(in_data_b), .w_data(w_data_b), .b_data(b_data_b),
        .mac_rst_acc(mac_rst_acc_b), .mac_ld_acc(mac_ld_acc_b),
        .cur_input(cur_input_b), .cur_weight(cur_weight_b), .cur_bias(cur_bias_b),
        .mac_result(mac_result_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_idx(out_idx_b)
`ifdef PERF_CNT_EN
        , .stall_cnt(stall_cnt_b)
`endif
    );

    // Synchronous-read memories (data one cycle after address) and the MAC stub.
    always @(posedge clk) begin
        in_data   <= in_mem[in_addr];
        w_data    <= w_mem[w_addr];
        b_data    <= b_mem[b_addr];
        in_data_b <= in_mem[in_addr_b];
        w_data_b  <= w_mem[w_addr_b];
        b_data_b  <= b_mem[b_addr_b];
    end
    assign mac_result   = cur_bias ^ 8'h5A;
    assign mac_result_b = cur_bias_b ^ 8'h5A;

    int cyc = 0, ld_cnt = 0, rst_cnt = 0, both_cnt = 0, done_cnt = 0, ld_cnt_b = 0;
    logic [15:0] pair_q[$], res_q[$], pair_q_b[$], res_q_b[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_ld_acc) begin
            ld_cnt <= ld_cnt + 1;
            pair_q.push_back({cur_input, cur_weight});
        end
        if (mac_rst_acc) rst_cnt <= rst_cnt + 1;
        if (mac_rst_acc && mac_ld_acc) both_cnt <= both_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (out_valid && out_ready) res_q.push_back({out_idx, out_data});
        if (mac_ld_acc_b) begin
            ld_cnt_b <= ld_cnt_b + 1;
            pair_q_b.push_back({cur_input_b, cur_weight_b});
        end
        if (out_valid_b && out_ready) res_q_b.push_back({out_idx_b, out_data_b});
    end

    int n_tests = 0, n_fail = 0;
    int t_start, pb, rb, lb, rsb, bb, db;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) begin
            in_mem[i] = 8'($urandom);
            w_mem[i]  = 8'($urandom);
            b_mem[i]  = 8'($urandom);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_ctl"}, {27'd0, busy, done, mac_rst_acc, mac_ld_acc, out_valid}, 32'd0);
        check({tag, "_in_addr"}, 32'(in_addr), 32'd0);
        check({tag, "_w_addr"}, 32'(w_addr), 32'd0);
        check({tag, "_b_addr"}, 32'(b_addr), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    endtask

    task automatic start_a();
        pb = pair_q.size(); rb = res_q.size();
        lb = ld_cnt; rsb = rst_cnt; bb = both_cnt; db = done_cnt;
        start = 1'b1;
        t_start = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int exp_lat);
        for (int i = 0; i < 400 && done !== 1'b1; i++) step();
        check({tag, "_done_latency"}, 32'(cyc - t_start), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        step();
        step();
    endtask

    // Expected layer: pairs (in_mem[k], w_mem[n*NI+k]) in order, results b_mem[n]^5A.
    task automatic check_layer_a(input string tag);
        check({tag, "_ld_pulses"}, 32'(ld_cnt - lb), 32'(NN * NI));
        check({tag, "_rst_pulses"}, 32'(rst_cnt - rsb), 32'(NN));
        check({tag, "_rst_ld_overlap"}, 32'(both_cnt - bb), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt - db), 32'd1);
        check({tag, "_result_count"}, 32'(res_q.size() - rb), 32'(NN));
        for (int n = 0; n < NN; n++) begin
            check({tag, "_result"}, 32'(res_q[rb + n]), {16'd0, 8'(n), b_mem[n] ^ 8'h5A});
            for (int k = 0; k < NI; k++)
                check({tag, "_pair"}, 32'(pair_q[pb + n * NI + k]), {16'd0, in_mem[k], w_mem[n * NI + k]});
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start_b = 1'b0; out_ready = 1'b1;
        fill_mem();
        step(); step(); step();
        check_reset_a("reset");
        check("reset_b_ctl", {29'd0, busy_b, out_valid_b, done_b}, 32'd0);
        rst = 1'b1;
        step();

        // Directed biases, cycle-accurate first neuron, then the full layer.
        b_mem[0] = 8'h01; b_mem[1] = 8'h82; b_mem[2] = 8'h7F; b_mem[3] = 8'h00;
        start_a();
        check("t1_clr", {29'd0, mac_rst_acc, mac_ld_acc, busy}, 32'b101);
        check("t1_clr_in_addr", 32'(in_addr), 32'd0);
        check("t1_clr_w_addr", 32'(w_addr), 32'd0);
        for (int k = 0; k < NI; k++) begin
            step();
            check("t1_acc_ld", {30'd0, mac_rst_acc, mac_ld_acc}, 32'b01);
            if (k < NI - 1) check("t1_acc_in_addr", 32'(in_addr), 32'(k + 1));
            else            check("t1_acc_b_addr", 32'(b_addr), 32'd0);
        end
        step();
        check("t1_bias", {30'd0, mac_ld_acc, out_valid}, 32'd0);
        step();
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", 32'(out_data), 32'h5B);
        check("t1_out_idx", 32'(out_idx), 32'd0);
        wait_done_a("t1", NI * 7 + 1 + (NN - 1) * 0 + 0 * NN + (NN - 1) * 0 + 0);
        check_layer_a("t1");

        // Back-pressure on the first result for five cycles.
        fill_mem();
        out_ready = 1'b0;
        start_a();
        for (int i = 0; i < 50 && out_valid !== 1'b1; i++) step();
        check("stall_first_valid", 32'(cyc - t_start), 32'(NI + 3));
        begin
            int ld0, rs0;
            ld0 = ld_cnt; rs0 = rst_cnt;
            for (int i = 0; i < 5; i++) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(b_mem[0] ^ 8'h5A));
                check("stall_idx", 32'(out_idx), 32'd0);
                step();
            end
            check("stall_no_pulses", 32'((ld_cnt - ld0) + (rst_cnt - rs0)), 32'd0);
            check("stall_still_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        wait_done_a("stall", 7 * NN + 1 + 5);
        check_layer_a("stall");
`ifdef PERF_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'd5);
        step(); step();
        check("stall_cnt_hold", 32'(stall_cnt), 32'd5);
`endif

        // start re-pulsed during ACC is ignored.
        fill_mem();
        start_a();
        step(); step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done_a("repulse", 7 * NN + 1);
        check_layer_a("repulse");
`ifdef PERF_CNT_EN
        check("stall_cnt_cleared", 32'(stall_cnt), 32'd0);
`endif

        // Reset in the third ACC cycle, then a fresh run.
        fill_mem();
        start_a();
        step(); step(); step();
        rst = 1'b0;
        step();
        check_reset_a("midrst");
        rst = 1'b1;
        step();
        start_a();
        check("midrst_restart_clr", {30'd0, mac_rst_acc, mac_ld_acc}, 32'b10);
        wait_done_a("midrst", 7 * NN + 1);
        check_layer_a("midrst");

        // Single-input layer on the second instance.
        fill_mem();
        begin
            int lbb, pbb, rbb;
            lbb = ld_cnt_b; pbb = pair_q_b.size(); rbb = res_q_b.size();
            start_b = 1'b1;
            t_start = cyc;
            step();
            start_b = 1'b0;
            for (int i = 0; i < 50 && out_valid_b !== 1'b1; i++) step();
            check("n1_first_valid", 32'(cyc - t_start), 32'd4);
            for (int i = 0; i < 50 && done_b !== 1'b1; i++) step();
            check("n1_done_latency", 32'(cyc - t_start), 32'd9);
            step();
            check("n1_ld_pulses", 32'(ld_cnt_b - lbb), 32'd2);
            for (int n = 0; n < 2; n++) begin
                check("n1_result", 32'(res_q_b[rbb + n]), {16'd0, 8'(n), b_mem[n] ^ 8'h5A});
                check("n1_pair", 32'(pair_q_b[pbb + n]), {16'd0, in_mem[0], w_mem[n]});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
